// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the streaming stopwatch renderer:
// FSM encoding, seven-segment masks, digit order and a double-dabble step.
package stopwatch_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CONVERT = 2'd2,
    ST_COMMIT  = 2'd3
  } sw_state_e;

  typedef enum logic [1:0] {
    CELL_NONE  = 2'd0,
    CELL_GLYPH = 2'd1,
    CELL_SEP   = 2'd2
  } cell_kind_e;

  localparam int CONVERT_CYCLES = 10;

  // Displayed digit positions, left to right: H MM SS mmm
  localparam int DIG_H  = 0;
  localparam int DIG_M1 = 1;
  localparam int DIG_M0 = 2;
  localparam int DIG_S1 = 3;
  localparam int DIG_S0 = 4;
  localparam int DIG_m2 = 5;
  localparam int DIG_m1 = 6;
  localparam int DIG_m0 = 7;

  // Segment bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // One double-dabble iteration on a 3-digit BCD accumulator; caller keeps
  // only as many low bits as its field needs.
  function automatic logic [12:0] dd_shift(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] adj;
    for (int i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return {adj, bit_in};
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD to seven-segment mask; codes 10-15 render blank.
module seven_seg_decoder
  import stopwatch_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_digit_renderer.sv
// Streams the stopwatch readout one pixel per cycle from VGA coordinates.
// Optional macro SEPARATORS_EN adds colon and decimal-point slots.
module stopwatch_digit_renderer
  import stopwatch_display_pkg::*;
#(
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int NUMBER_OF_DIGITS = 8,
  parameter int DIGIT_WIDTH      = SCREEN_WIDTH / (2 * NUMBER_OF_DIGITS),
  parameter int DIGIT_HEIGHT     = 2 * DIGIT_WIDTH,
  parameter int SEG_THICK        = DIGIT_HEIGHT / 10,
  parameter int DIGIT_GAP        = 8,
  parameter int ORIGIN_X         = 128,
  parameter int ORIGIN_Y         = 200,
  parameter int SEP_WIDTH        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       pixel_valid,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [9:0] milliseconds,
  output logic       pixel_on,
  output logic       pixel_on_valid,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int P = DIGIT_WIDTH + DIGIT_GAP;
`ifdef SEPARATORS_EN
  localparam int SEP_W_EFF = SEP_WIDTH;
`else
  localparam int SEP_W_EFF = 0 * SEP_WIDTH;
`endif

  localparam logic [9:0] L_T    = 10'(SEG_THICK);
  localparam logic [9:0] L_W_T  = 10'(DIGIT_WIDTH - SEG_THICK);
  localparam logic [9:0] L_H    = 10'(DIGIT_HEIGHT);
  localparam logic [9:0] L_H_T  = 10'(DIGIT_HEIGHT - SEG_THICK);
  localparam logic [9:0] L_HALF = 10'(DIGIT_HEIGHT / 2);
  localparam logic [9:0] L_G_LO = 10'((DIGIT_HEIGHT - SEG_THICK) / 2);
  localparam logic [9:0] L_G_HI = 10'((DIGIT_HEIGHT + SEG_THICK) / 2);

  // Left column of glyph k; each separator slot before it pushes it right.
  function automatic int glyph_x(input int k);
    int n_slots;
    n_slots = (k >= 1 ? 1 : 0) + (k >= 3 ? 1 : 0) + (k >= 5 ? 1 : 0);
    return ORIGIN_X + k * P + n_slots * SEP_W_EFF;
  endfunction

  // ---------------- snapshot / conversion FSM ----------------
  sw_state_e   r_state;
  sw_state_e   w_state_next;
  logic [3:0]  r_cnt;
  logic [9:0]  r_h_bin, r_m_bin, r_s_bin, r_ms_bin;
  logic [3:0]  r_h_bcd;
  logic [7:0]  r_m_bcd, r_s_bcd;
  logic [11:0] r_ms_bcd;
  logic [3:0]  r_disp [NUMBER_OF_DIGITS];

  logic [3:0]  w_h_clamp;
  logic [5:0]  w_m_clamp, w_s_clamp;
  logic [9:0]  w_ms_clamp;

  assign w_h_clamp  = (hours > 4'd9)           ? 4'd9    : hours;
  assign w_m_clamp  = (minutes > 6'd59)        ? 6'd59   : minutes;
  assign w_s_clamp  = (seconds > 6'd59)        ? 6'd59   : seconds;
  assign w_ms_clamp = (milliseconds > 10'd999) ? 10'd999 : milliseconds;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // frame_start is only looked at in IDLE, so pulses during a conversion drop.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (frame_start) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_CONVERT;
      ST_CONVERT: if (r_cnt == 4'(CONVERT_CYCLES - 1)) w_state_next = ST_COMMIT;
      ST_COMMIT:  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_h_bin  <= '0;
      r_m_bin  <= '0;
      r_s_bin  <= '0;
      r_ms_bin <= '0;
      r_h_bcd  <= '0;
      r_m_bcd  <= '0;
      r_s_bcd  <= '0;
      r_ms_bcd <= '0;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) r_disp[i] <= '0;
    end else begin
      case (r_state)
        ST_CAPTURE: begin
          r_cnt    <= '0;
          r_h_bin  <= {6'd0, w_h_clamp};
          r_m_bin  <= {4'd0, w_m_clamp};
          r_s_bin  <= {4'd0, w_s_clamp};
          r_ms_bin <= w_ms_clamp;
          r_h_bcd  <= '0;
          r_m_bcd  <= '0;
          r_s_bcd  <= '0;
          r_ms_bcd <= '0;
        end
        ST_CONVERT: begin
          // All fields are 10 bits wide so one shared count finishes them together.
          r_cnt    <= r_cnt + 4'd1;
          r_h_bcd  <= 4'(dd_shift({8'd0, r_h_bcd}, r_h_bin[9]));
          r_m_bcd  <= 8'(dd_shift({4'd0, r_m_bcd}, r_m_bin[9]));
          r_s_bcd  <= 8'(dd_shift({4'd0, r_s_bcd}, r_s_bin[9]));
          r_ms_bcd <= 12'(dd_shift(r_ms_bcd, r_ms_bin[9]));
          r_h_bin  <= {r_h_bin[8:0], 1'b0};
          r_m_bin  <= {r_m_bin[8:0], 1'b0};
          r_s_bin  <= {r_s_bin[8:0], 1'b0};
          r_ms_bin <= {r_ms_bin[8:0], 1'b0};
        end
        ST_COMMIT: begin
          r_disp[DIG_H]  <= r_h_bcd;
          r_disp[DIG_M1] <= r_m_bcd[7:4];
          r_disp[DIG_M0] <= r_m_bcd[3:0];
          r_disp[DIG_S1] <= r_s_bcd[7:4];
          r_disp[DIG_S0] <= r_s_bcd[3:0];
          r_disp[DIG_m2] <= r_ms_bcd[11:8];
          r_disp[DIG_m1] <= r_ms_bcd[7:4];
          r_disp[DIG_m0] <= r_ms_bcd[3:0];
        end
        default: ;
      endcase
    end
  end

  // ---------------- render stage 1: cell hit and local coordinates ----------------
  cell_kind_e w_kind;
  logic [2:0] w_idx;
  logic [9:0] w_lx;
  logic [9:0] w_ly;
  logic       w_row_hit;

  cell_kind_e r_s1_kind;
  logic [2:0] r_s1_idx;
  logic [9:0] r_s1_lx;
  logic [9:0] r_s1_ly;
  logic       r_s1_valid;

  always_comb begin
    w_kind    = CELL_NONE;
    w_idx     = '0;
    w_lx      = '0;
    w_ly      = pixel_y - 10'(ORIGIN_Y);
    w_row_hit = pixel_valid
              && (pixel_x < 10'(SCREEN_WIDTH)) && (pixel_y < 10'(SCREEN_HEIGHT))
              && (pixel_y >= 10'(ORIGIN_Y)) && (pixel_y < 10'(ORIGIN_Y + DIGIT_HEIGHT));
    for (int k = 0; k < NUMBER_OF_DIGITS; k++) begin
      if (pixel_x >= 10'(glyph_x(k)) && pixel_x < 10'(glyph_x(k) + DIGIT_WIDTH)) begin
        w_kind = CELL_GLYPH;
        w_idx  = 3'(k);
        w_lx   = pixel_x - 10'(glyph_x(k));
      end
    end
`ifdef SEPARATORS_EN
    for (int s = 0; s < 3; s++) begin
      if (pixel_x >= 10'(glyph_x(2 * s) + DIGIT_WIDTH) &&
          pixel_x <  10'(glyph_x(2 * s) + DIGIT_WIDTH + SEP_WIDTH)) begin
        w_kind = CELL_SEP;
        w_idx  = 3'(s);
        w_lx   = pixel_x - 10'(glyph_x(2 * s) + DIGIT_WIDTH);
      end
    end
`endif
    if (!w_row_hit) w_kind = CELL_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_kind  <= CELL_NONE;
      r_s1_idx   <= '0;
      r_s1_lx    <= '0;
      r_s1_ly    <= '0;
    end else begin
      r_s1_valid <= pixel_valid;
      r_s1_kind  <= w_kind;
      r_s1_idx   <= w_idx;
      r_s1_lx    <= w_lx;
      r_s1_ly    <= w_ly;
    end
  end

  // ---------------- render stage 2: segment lookup ----------------
  logic [3:0] w_digit;
  logic [6:0] w_seg;
  logic       w_lit_glyph;
  logic       w_lit_sep;
  logic       w_pix_next;
  logic       r_pix_on;
  logic       r_pix_valid;

  assign w_digit = r_disp[r_s1_idx];

  seven_seg_decoder u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  always_comb begin
    w_lit_glyph = 1'b0;
    if (w_seg[6] && r_s1_ly < L_T)                           w_lit_glyph = 1'b1;
    if (w_seg[5] && r_s1_lx >= L_W_T && r_s1_ly <  L_HALF)   w_lit_glyph = 1'b1;
    if (w_seg[4] && r_s1_lx >= L_W_T && r_s1_ly >= L_HALF)   w_lit_glyph = 1'b1;
    if (w_seg[3] && r_s1_ly >= L_H_T)                        w_lit_glyph = 1'b1;
    if (w_seg[2] && r_s1_lx <  L_T   && r_s1_ly >= L_HALF)   w_lit_glyph = 1'b1;
    if (w_seg[1] && r_s1_lx <  L_T   && r_s1_ly <  L_HALF)   w_lit_glyph = 1'b1;
    if (w_seg[0] && r_s1_ly >= L_G_LO && r_s1_ly < L_G_HI)   w_lit_glyph = 1'b1;
  end

`ifdef SEPARATORS_EN
  localparam logic [9:0] L_DOT_X0 = 10'((SEP_WIDTH - SEG_THICK) / 2);
  localparam logic [9:0] L_DOT_X1 = 10'((SEP_WIDTH - SEG_THICK) / 2 + SEG_THICK);
  localparam logic [9:0] L_Q1_LO  = 10'(DIGIT_HEIGHT / 4);
  localparam logic [9:0] L_Q1_HI  = 10'(DIGIT_HEIGHT / 4 + SEG_THICK);
  localparam logic [9:0] L_Q3_LO  = 10'(3 * DIGIT_HEIGHT / 4 - SEG_THICK);
  localparam logic [9:0] L_Q3_HI  = 10'(3 * DIGIT_HEIGHT / 4);

  // Slots 0 and 1 are colons, slot 2 is the decimal point on the baseline.
  always_comb begin
    w_lit_sep = 1'b0;
    if (r_s1_lx >= L_DOT_X0 && r_s1_lx < L_DOT_X1) begin
      if (r_s1_idx == 3'd2)
        w_lit_sep = (r_s1_ly >= L_H_T) && (r_s1_ly < L_H);
      else
        w_lit_sep = ((r_s1_ly >= L_Q1_LO) && (r_s1_ly < L_Q1_HI)) ||
                    ((r_s1_ly >= L_Q3_LO) && (r_s1_ly < L_Q3_HI));
    end
  end
`else
  assign w_lit_sep = 1'b0;
`endif

  always_comb begin
    w_pix_next = 1'b0;
    case (r_s1_kind)
      CELL_GLYPH: w_pix_next = w_lit_glyph;
      CELL_SEP:   w_pix_next = w_lit_sep;
      default:    w_pix_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_on    <= 1'b0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_on    <= w_pix_next;
      r_pix_valid <= r_s1_valid;
    end
  end

  assign pixel_on       = r_pix_on;
  assign pixel_on_valid = r_pix_valid;

endmodule

// File: tb/tb_stopwatch_digit_renderer.sv
// Directed bench for stopwatch_digit_renderer: vector table for the reset
// display, then hand-written sequences for snapshot, clamp, ignore and reset.
module tb_stopwatch_digit_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       pixel_valid;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [9:0] milliseconds;
  logic       pixel_on;
  logic       pixel_on_valid;
  logic       busy;
  logic [1:0] dbg_state;

  stopwatch_digit_renderer dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .pixel_valid    (pixel_valid),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .hours          (hours),
    .minutes        (minutes),
    .seconds        (seconds),
    .milliseconds   (milliseconds),
    .pixel_on       (pixel_on),
    .pixel_on_valid (pixel_on_valid),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef SEPARATORS_EN
  localparam int SEP = 16;
`else
  localparam int SEP = 0;
`endif

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  string      name_q[$];

  typedef struct {
    string name;
    int    k;
    int    lx;
    int    ly;
    logic  v;
    logic  exp_on;
  } vec_t;

  vec_t vecs[14];

  // Expected glyph placement: 40-wide glyphs at pitch 48 from x=128, y=200.
  function automatic int gx(input int k);
    return 128 + k * 48 + SEP * ((k >= 1 ? 1 : 0) + (k >= 3 ? 1 : 0) + (k >= 5 ? 1 : 0));
  endfunction

  // Expected segments {a,b,c,d,e,f,g} for each decimal digit.
  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Probe point inside each segment s = a,b,c,d,e,f,g that no other segment covers.
  function automatic int probe_lx(input int s);
    case (s)
      1, 2:    return 36;
      4, 5:    return 2;
      default: return 20;
    endcase
  endfunction

  function automatic int probe_ly(input int s);
    case (s)
      0:       return 2;
      1, 5:    return 20;
      2, 4:    return 60;
      3:       return 76;
      default: return 40;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check();
    logic [1:0] e;
    string      n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    check({n, " valid"}, 32'(pixel_on_valid), 32'(e[1]));
    check({n, " on"}, 32'(pixel_on), 32'(e[0]));
  endtask

  // One pixel per cycle; the result for a pixel appears two edges after it is driven.
  task automatic drive_pix(input int x, input int y, input logic v, input logic exp_on,
                           input string name);
    pixel_valid = v;
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    exp_q.push_back({v, exp_on & v});
    name_q.push_back(name);
    tick();
    if (exp_q.size() >= 2) pop_check();
  endtask

  task automatic flush();
    pixel_valid = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      tick();
      pop_check();
    end
  endtask

  // digs holds the eight expected digits as nibbles, H first.
  task automatic scan_all(input logic [31:0] digs, input string tag);
    logic [6:0] m;
    for (int k = 0; k < 8; k++) begin
      m = exp_seg(int'(digs[31 - 4*k -: 4]));
      for (int s = 0; s < 7; s++)
        drive_pix(gx(k) + probe_lx(s), 200 + probe_ly(s), 1'b1, m[6 - s],
                  $sformatf("%s digit%0d seg%0d", tag, k, s));
    end
    flush();
  endtask

  task automatic run_frame(input int h, input int m, input int s, input int ms,
                           output int busy_cycles);
    hours        = 4'(h);
    minutes      = 6'(m);
    seconds      = 6'(s);
    milliseconds = 10'(ms);
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
    busy_cycles  = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      tick();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    reset        = 1'b1;
    frame_start  = 1'b0;
    pixel_valid  = 1'b0;
    pixel_x      = '0;
    pixel_y      = '0;
    hours        = '0;
    minutes      = '0;
    seconds      = '0;
    milliseconds = '0;

    vecs[0]  = '{"a of 0",              0, 10,  2, 1'b1, 1'b1};
    vecs[1]  = '{"g of 0 off",          0, 10, 40, 1'b1, 1'b0};
    vecs[2]  = '{"e of 0",              0,  2, 60, 1'b1, 1'b1};
    vecs[3]  = '{"glyph interior",      0, 20, 50, 1'b1, 1'b0};
    vecs[4]  = '{"gap column",          0, 44,  2, 1'b1, 1'b0};
    vecs[5]  = '{"left of origin",      0, -1,  2, 1'b1, 1'b0};
    vecs[6]  = '{"above glyph row",     0, 10, -1, 1'b1, 1'b0};
    vecs[7]  = '{"d last row",          0, 10, 79, 1'b1, 1'b1};
    vecs[8]  = '{"below glyph row",     0, 10, 80, 1'b1, 1'b0};
    vecs[9]  = '{"last glyph a",        7, 39,  0, 1'b1, 1'b1};
    vecs[10] = '{"after last glyph",    7, 40,  0, 1'b1, 1'b0};
    vecs[11] = '{"pixel_valid low",     0, 10,  2, 1'b0, 1'b0};
    vecs[12] = '{"b bottom row",        0, 39, 39, 1'b1, 1'b1};
    vecs[13] = '{"c top row",           0, 39, 40, 1'b1, 1'b1};

    repeat (3) tick();
    check("reset pixel_on", 32'(pixel_on), 32'd0);
    check("reset pixel_on_valid", 32'(pixel_on_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // Reset display renders all zeros.
    for (int i = 0; i < 14; i++)
      drive_pix(gx(vecs[i].k) + vecs[i].lx, 200 + vecs[i].ly, vecs[i].v, vecs[i].exp_on,
                vecs[i].name);
    flush();

    // hours = 1: segment a goes dark, b stays lit; busy lasts 12 cycles.
    run_frame(1, 0, 0, 0, n);
    check("busy cycles h=1", 32'(n), 32'd12);
    drive_pix(138, 202, 1'b1, 1'b0, "a of 1 off");
    drive_pix(167, 210, 1'b1, 1'b1, "b of 1");
    flush();

    // Clamping: 12 -> 9, 63 -> 59, 62 -> 59, 1023 -> 999.
    run_frame(12, 63, 62, 1023, n);
    check("busy cycles clamp", 32'(n), 32'd12);
    drive_pix(gx(1) + 10, 240, 1'b1, 1'b1, "g of clamped M1");
    flush();
    scan_all(32'h95959999, "clamp");

    run_frame(3, 47, 8, 506, n);
    check("busy cycles mixed", 32'(n), 32'd12);
    scan_all(32'h34708506, "mixed");

    // Second frame_start 5 cycles into a conversion must be ignored.
    hours        = 4'd2;
    minutes      = 6'd0;
    seconds      = 6'd0;
    milliseconds = 10'd0;
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      frame_start = (i == 4);
      if (i == 4) begin
        hours   = 4'd7;
        minutes = 6'd33;
      end
      tick();
    end
    frame_start = 1'b0;
    check("busy cycles with repeat", 32'(n), 32'd12);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle after repeat %0d", i), 32'(busy), 32'd0);
      tick();
    end
    scan_all(32'h20000000, "repeat ignored");

    // Reset in the middle of CONVERT aborts and clears the display.
    hours = 4'd5;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();
    check("mid convert state", 32'(dbg_state), 32'd2);
    pixel_valid = 1'b1;
    pixel_x     = 10'd138;
    pixel_y     = 10'd202;
    reset = 1'b1;
    tick();
    check("abort busy", 32'(busy), 32'd0);
    check("abort state", 32'(dbg_state), 32'd0);
    check("abort valid cycle0", 32'(pixel_on_valid), 32'd0);
    reset = 1'b0;
    tick();
    check("abort valid cycle1", 32'(pixel_on_valid), 32'd0);
    tick();
    check("abort valid cycle2", 32'(pixel_on_valid), 32'd1);
    check("abort a of 0", 32'(pixel_on), 32'd1);
    pixel_valid = 1'b0;
    tick();
    tick();
    scan_all(32'h00000000, "after abort");

    // Separator slot 0 (colon) sits at x 168..183 when enabled, else it is gap.
    drive_pix(172, 220, 1'b1, (SEP != 0), "colon upper dot");
    drive_pix(172, 240, 1'b1, 1'b0, "colon between dots");
`ifdef SEPARATORS_EN
    drive_pix(172, 255, 1'b1, 1'b1, "colon lower dot");
    drive_pix(396, 275, 1'b1, 1'b1, "decimal point");
    drive_pix(396, 260, 1'b1, 1'b0, "above decimal point");
`endif
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
